// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between producers/transmitter and uart_tx_feeder.
// The feeder uses the slave view; the producer/transmitter side uses master.
interface uart_tx_feeder_if #(
   parameter int unsigned ADDR_W = 4
);
   logic [7:0]      wr_data;
   logic            wr_en;
   logic            clr_err;
   logic            tx_done;
   logic [7:0]      data_byte;
   logic            send_en;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] fifo_count;
   logic            busy;
   logic            overflow;
   logic            timeout_err;

   modport master (
      output wr_data, wr_en, clr_err, tx_done,
      input  data_byte, send_en, full, empty, fifo_count, busy, overflow, timeout_err
   );

   modport slave (
      input  wr_data, wr_en, clr_err, tx_done,
      output data_byte, send_en, full, empty, fifo_count, busy, overflow, timeout_err
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus handshake FSM that feeds a UART transmitter one byte at a
// time, with a watchdog that aborts a byte if tx_done never arrives.
module uart_tx_feeder #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_feeder_if.slave bus
);
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned TMR_W = 24;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DONE = 2'd1,
      GAP       = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [7:0]         data_byte_q, data_byte_d;
   logic               send_en_q, send_en_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               busy_q, busy_d;
   logic               overflow_q, overflow_d;
   logic               timeout_err_q, timeout_err_d;
   logic               push, pop, ovf_set, tmo_set;
   logic [7:0]         mem_q [DEPTH];

   // Next-state, FIFO bookkeeping and registered-output logic.
   always_comb begin
      state_d       = state_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      timer_d       = timer_q;
      data_byte_d   = data_byte_q;
      send_en_d     = 1'b0;
      pop           = 1'b0;
      tmo_set       = 1'b0;

      // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
      push    = bus.wr_en && (count_q != CNT_FULL);
      ovf_set = bus.wr_en && (count_q == CNT_FULL);

      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop         = 1'b1;
               data_byte_d = mem_q[rd_ptr_q];
               send_en_d   = 1'b1;
               timer_d     = '0;
               state_d     = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            timer_d = timer_q + TMR_W'(1);
            if (bus.tx_done) begin
               state_d = GAP;
            end else if (timer_q == TMR_LAST) begin
               tmo_set = 1'b1;
               state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);

      full_d        = (count_d == CNT_FULL);
      empty_d       = (count_d == '0);
      busy_d        = (state_d != IDLE);
      overflow_d    = ovf_set || (overflow_q && !bus.clr_err);
      timeout_err_d = tmo_set || (timeout_err_q && !bus.clr_err);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         timer_q       <= '0;
         data_byte_q   <= '0;
         send_en_q     <= 1'b0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         busy_q        <= 1'b0;
         overflow_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         timer_q       <= timer_d;
         data_byte_q   <= data_byte_d;
         send_en_q     <= send_en_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         busy_q        <= busy_d;
         overflow_q    <= overflow_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Storage array carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.data_byte   = data_byte_q;
   assign bus.send_en     = send_en_q;
   assign bus.full        = full_q;
   assign bus.empty       = empty_q;
   assign bus.fifo_count  = count_q;
   assign bus.busy        = busy_q;
   assign bus.overflow    = overflow_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_uart_tx_feeder;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned TIMEOUT = 50;
   localparam int          BIG     = 32'h7fff_ffff;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: byte queue plus the cycle from which the sender is free.
   byte unsigned mq[$];
   logic [7:0]   m_data;
   logic         m_send, m_ovf, m_tmo;
   int           idle_at  = 0;
   int           send_cyc = 0;
   bit           in_flight;

   bit           auto_en   = 1'b0;
   int           auto_dly  = 1;
   int           done_due  = -1;
   int           last_done = -1;
   int           last_send = -1;
   byte unsigned sent[$];

   typedef struct {
      int         reps;
      bit         we;
      logic [7:0] wd;
      bit         td;
      bit         clr;
      bit         r;
      bit         e_send;
      logic [7:0] e_data;
      int         e_cnt;
      bit         e_busy;
      bit         e_empty;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_update(input int c, input bit we, input logic [7:0] wd,
                               input bit tx, input bit clr, input bit r);
      bit full_pre, tmo_set;
      if (r) begin
         mq.delete();
         idle_at   = c + 1;
         in_flight = 1'b0;
         m_send    = 1'b0;
         m_data    = 8'h00;
         m_ovf     = 1'b0;
         m_tmo     = 1'b0;
      end else begin
         full_pre = (mq.size() == int'(DEPTH));
         tmo_set  = 1'b0;
         if (in_flight && c >= send_cyc) begin
            if (tx) begin
               in_flight = 1'b0;
               idle_at   = c + 2;
            end else if (c - send_cyc == int'(TIMEOUT) - 1) begin
               in_flight = 1'b0;
               idle_at   = c + 2;
               tmo_set   = 1'b1;
            end
         end
         m_send = 1'b0;
         if (c >= idle_at && mq.size() != 0) begin
            m_data    = mq.pop_front();
            m_send    = 1'b1;
            in_flight = 1'b1;
            send_cyc  = c + 1;
            idle_at   = BIG;
         end
         if (we && !full_pre) mq.push_back(wd);
         m_ovf = (we && full_pre) || (m_ovf && !clr);
         m_tmo = tmo_set || (m_tmo && !clr);
      end
   endtask

   task automatic model_check();
      chk("send_en",     32'(bus.send_en),     32'(m_send));
      chk("data_byte",   32'(bus.data_byte),   32'(m_data));
      chk("fifo_count",  32'(bus.fifo_count),  32'(mq.size()));
      chk("full",        32'(bus.full),        32'(mq.size() == int'(DEPTH)));
      chk("empty",       32'(bus.empty),       32'(mq.size() == 0));
      chk("busy",        32'(bus.busy),        32'(cyc < idle_at));
      chk("overflow",    32'(bus.overflow),    32'(m_ovf));
      chk("timeout_err", 32'(bus.timeout_err), 32'(m_tmo));
   endtask

   // One clock: drive inputs, advance model on the edge, check on the falling edge.
   task automatic step(input bit we, input logic [7:0] wd, input bit td,
                       input bit clr, input bit r);
      bit tx;
      tx = td || (auto_en && cyc == done_due);
      rst         = r;
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.tx_done = tx;
      bus.clr_err = clr;
      if (tx) last_done = cyc;
      @(posedge clk);
      model_update(cyc, we, wd, tx, clr, r);
      cyc++;
      @(negedge clk);
      model_check();
      if (bus.send_en === 1'b1) begin
         last_send = cyc;
         sent.push_back(bus.data_byte);
         done_due = cyc + auto_dly;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_send(input int maxc, input string name);
      int n;
      n = 0;
      do begin
         idle(1);
         n++;
      end while (last_send != cyc && n < maxc);
      if (last_send != cyc) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no send_en within %0d cycles", name, maxc);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          n, s0, s1, nmis, saved;
      logic [7:0]  d;
      byte unsigned wl[$];

      rst = 1'b1;
      bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_done = 1'b0; bus.clr_err = 1'b0;

      // reps, we, wd, td, clr, rst | send, data, count, busy, empty
      tbl[0]  = '{2,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
      tbl[1]  = '{1,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0};
      tbl[2]  = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b1, 1'b1};
      tbl[3]  = '{20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 1'b1, 1'b1};
      tbl[4]  = '{1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 1'b1, 1'b1};
      tbl[5]  = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 1'b0, 1'b1};
      tbl[6]  = '{1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 1'b0, 1'b1};
      tbl[7]  = '{1,  1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0, 1'b0};
      tbl[8]  = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1'b1, 1'b1};
      tbl[9]  = '{1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1'b1, 1'b1};
      tbl[10] = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1'b0, 1'b1};

      for (int i = 0; i < 11; i++) begin
         repeat (tbl[i].reps) step(tbl[i].we, tbl[i].wd, tbl[i].td, tbl[i].clr, tbl[i].r);
         chk($sformatf("vec%0d.send_en", i),    32'(bus.send_en),    32'(tbl[i].e_send));
         chk($sformatf("vec%0d.data_byte", i),  32'(bus.data_byte),  32'(tbl[i].e_data));
         chk($sformatf("vec%0d.fifo_count", i), 32'(bus.fifo_count), 32'(tbl[i].e_cnt));
         chk($sformatf("vec%0d.busy", i),       32'(bus.busy),       32'(tbl[i].e_busy));
         chk($sformatf("vec%0d.empty", i),      32'(bus.empty),      32'(tbl[i].e_empty));
      end

      // Burst of 16 behind an in-flight byte fills the FIFO; then overflow and clear.
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      wait_send(5, "burst.first");
      chk("burst.first_data", 32'(bus.data_byte), 32'h0000_00EE);
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("burst.full",  32'(bus.full),       32'd1);
      chk("burst.count", 32'(bus.fifo_count), 32'd16);
      step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      chk("ovf.flag",  32'(bus.overflow),   32'd1);
      chk("ovf.count", 32'(bus.fifo_count), 32'd16);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("ovf.clear", 32'(bus.overflow), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         wait_send(6, "burst.send");
         chk($sformatf("burst.order%0d", i), 32'(bus.data_byte), 32'(i));
         chk($sformatf("burst.spacing%0d", i), 32'(last_send - last_done), 32'd3);
         idle(int'($urandom_range(0, 5)));
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      idle(12);
      chk("burst.drained", 32'(bus.empty), 32'd1);

      // Wrap and concurrent push/pop with an auto-responding transmitter.
      auto_en  = 1'b1;
      auto_dly = 1;
      sent.delete();
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         wl.push_back(d);
         step(1'b1, d, 1'b0, 1'b0, 1'b0);
      end
      n = 0;
      while (sent.size() < 8 && n < 200) begin idle(1); n++; end
      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom);
         wl.push_back(d);
         step(1'b1, d, 1'b0, 1'b0, 1'b0);
      end
      n = 0;
      while ((bus.busy || !bus.empty) && n < 300) begin idle(1); n++; end
      chk("wrap.sent_count", 32'(sent.size()), 32'd22);
      nmis = 0;
      for (int k = 0; k < wl.size() && k < sent.size(); k++)
         if (wl[k] != sent[k]) nmis++;
      chk("wrap.order", 32'(nmis), 32'd0);

      // Watchdog: full timeout, then tx_done on the last timer cycle.
      auto_en = 1'b0;
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      chk("wdog.send0", 32'(bus.send_en), 32'd1);
      s0 = cyc;
      n = 0;
      while (bus.timeout_err !== 1'b1 && n < 100) begin idle(1); n++; end
      chk("wdog.latency", 32'(cyc - s0), 32'(TIMEOUT));
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("wdog.cleared", 32'(bus.timeout_err), 32'd0);
      idle(1);
      chk("wdog.next_send", 32'(last_send - s0), 32'(TIMEOUT + 2));
      chk("wdog.next_data", 32'(bus.data_byte), 32'h0000_0022);
      s1 = last_send;
      idle(int'(TIMEOUT) - 1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("wdog.race_cyc",  32'(cyc - s1), 32'(TIMEOUT));
      chk("wdog.race_flag", 32'(bus.timeout_err), 32'd0);
      chk("wdog.race_gap",  32'(bus.busy), 32'd1);
      idle(1);
      chk("wdog.race_idle", 32'(bus.busy), 32'd0);

      // Reset while a byte is in flight with five more queued.
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      chk("rstmf.count_before", 32'(bus.fifo_count), 32'd5);
      chk("rstmf.busy_before",  32'(bus.busy), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("rstmf.empty",   32'(bus.empty),   32'd1);
      chk("rstmf.busy",    32'(bus.busy),    32'd0);
      chk("rstmf.send_en", 32'(bus.send_en), 32'd0);
      saved = last_send;
      idle(30);
      chk("rstmf.no_send", 32'(last_send), 32'(saved));

      // Randomized traffic in three phases: write-heavy, balanced, stalled transmitter.
      for (int i = 0; i < 3000; i++) begin
         int  mode;
         bit  we, td, clr, r;
         mode = (i / 500) % 3;
         we   = $urandom_range(0, 99) < ((mode == 0) ? 80 : 40);
         td   = $urandom_range(0, 99) < ((mode == 2) ? 1 : 15);
         clr  = $urandom_range(0, 39) == 0;
         r    = $urandom_range(0, 799) == 0;
         step(we, 8'($urandom), td, clr, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
